// File: rtl/amstrad_dma_pkg.sv
// amstrad_dma_pkg
// Shared definitions for the line-synchronous sound DMA sequencer:
// instruction opcodes, CONTROL instruction bit positions, CPU register
// select codes and the sequencer FSM state encoding.
package amstrad_dma_pkg;

    // Instruction opcodes, decoded from bits [15:12] of the instruction word
    localparam logic [3:0] OP_LOAD    = 4'h0;
    localparam logic [3:0] OP_PAUSE   = 4'h1;
    localparam logic [3:0] OP_REPEAT  = 4'h2;
    localparam logic [3:0] OP_CONTROL = 4'h4;

    // CONTROL instruction flag positions
    localparam int CTL_LOOP_BIT = 0;
    localparam int CTL_INT_BIT  = 4;
    localparam int CTL_STOP_BIT = 5;

    // CPU register select codes
    localparam logic [1:0] SEL_PTR    = 2'd0;
    localparam logic [1:0] SEL_PRESC  = 2'd1;
    localparam logic [1:0] SEL_CTRL   = 2'd2;
    localparam logic [1:0] SEL_STATUS = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCAN,
        ST_FETCH,
        ST_EXEC,
        ST_PSG_WR
    } state_e;

endpackage

// File: rtl/amstrad_dma_if.sv
// amstrad_dma_if
// Bus bundle between the DMA sequencer and its neighbours.
//   mem_req/mem_addr/mem_ack/mem_rdata : word read port towards the RAM arbiter
//   psg_we/psg_reg/psg_data/psg_ready  : register write port towards the PSG
// master : the sequencer side (drives requests)
// slave  : the memory / PSG side (drives acknowledges and read data)
interface amstrad_dma_if #(
    parameter int ADDR_W = 16
);
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [15:0]       mem_rdata;
    logic              psg_we;
    logic [3:0]        psg_reg;
    logic [7:0]        psg_data;
    logic              psg_ready;

    modport master (
        output mem_req, mem_addr, psg_we, psg_reg, psg_data,
        input  mem_ack, mem_rdata, psg_ready
    );

    modport slave (
        input  mem_req, mem_addr, psg_we, psg_reg, psg_data,
        output mem_ack, mem_rdata, psg_ready
    );
endinterface

// File: rtl/amstrad_dma_channel.sv
// amstrad_dma_channel
// State of one DMA channel: instruction pointer, prescaler, pause and loop
// counters, loop return address, enable and sticky interrupt flag.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   cfg_we/sel/wdata: CPU register write already addressed to this channel
//   irq_clr         : status write clearing this channel's irq
//   fetch_done      : sequencer fetched an instruction for this channel
//   fetch_next_ptr  : pointer value after that fetch
//   exec_instr/instr: sequencer executes instr for this channel
//   pause_step      : sequencer spends this channel's slot on a pause step
//   ptr, en, pausing, irq : channel status towards the sequencer
module amstrad_dma_channel
    import amstrad_dma_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_we,
    input  logic [1:0]        cfg_sel,
    input  logic [15:0]       cfg_wdata,
    input  logic              irq_clr,
    input  logic              fetch_done,
    input  logic [ADDR_W-1:0] fetch_next_ptr,
    input  logic              exec_instr,
    input  logic [15:0]       instr,
    input  logic              pause_step,
    output logic [ADDR_W-1:0] ptr,
    output logic              en,
    output logic              pausing,
    output logic              irq
);

    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W-1:0] loop_addr_q, loop_addr_d;
    logic [7:0]        prescale_q, prescale_d;
    logic [7:0]        presc_cnt_q, presc_cnt_d;
    logic [11:0]       pause_cnt_q, pause_cnt_d;
    logic [11:0]       loop_cnt_q, loop_cnt_d;
    logic              en_q, en_d;
    logic              irq_q, irq_d;
    logic              irq_set;

    always_comb begin
        ptr_d       = ptr_q;
        loop_addr_d = loop_addr_q;
        prescale_d  = prescale_q;
        presc_cnt_d = presc_cnt_q;
        pause_cnt_d = pause_cnt_q;
        loop_cnt_d  = loop_cnt_q;
        en_d        = en_q;
        irq_set     = 1'b0;

        if (fetch_done) begin
            ptr_d = fetch_next_ptr;
        end

        if (pause_step) begin
            if (presc_cnt_q == 8'd0) begin
                presc_cnt_d = prescale_q;
                pause_cnt_d = pause_cnt_q - 12'd1;
            end else begin
                presc_cnt_d = presc_cnt_q - 8'd1;
            end
        end

        if (exec_instr) begin
            case (instr[15:12])
                OP_PAUSE: pause_cnt_d = instr[11:0];
                OP_REPEAT: begin
                    // ptr already points past the REPEAT word here
                    loop_cnt_d  = instr[11:0];
                    loop_addr_d = ptr_q;
                end
                OP_CONTROL: begin
                    if (instr[CTL_LOOP_BIT] && (loop_cnt_q != 12'd0)) begin
                        loop_cnt_d = loop_cnt_q - 12'd1;
                        ptr_d      = loop_addr_q;
                    end
                    if (instr[CTL_INT_BIT]) begin
                        irq_set = 1'b1;
                    end
                    if (instr[CTL_STOP_BIT]) begin
                        en_d = 1'b0;
                    end
                end
                default: ;
            endcase
        end

        // CPU writes land after sequencer updates so they take effect immediately
        if (cfg_we) begin
            case (cfg_sel)
                SEL_PTR: begin
                    ptr_d       = ADDR_W'(cfg_wdata) & ~ADDR_W'(1);
                    loop_cnt_d  = 12'd0;
                    pause_cnt_d = 12'd0;
                end
                SEL_PRESC: begin
                    prescale_d  = cfg_wdata[7:0];
                    presc_cnt_d = cfg_wdata[7:0];
                end
                SEL_CTRL: en_d = cfg_wdata[0];
                default: ;
            endcase
        end

        // an INT in the same cycle as a status clear keeps the flag set
        irq_d = (irq_q & ~irq_clr) | irq_set;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q       <= '0;
            loop_addr_q <= '0;
            prescale_q  <= '0;
            presc_cnt_q <= '0;
            pause_cnt_q <= '0;
            loop_cnt_q  <= '0;
            en_q        <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            loop_addr_q <= loop_addr_d;
            prescale_q  <= prescale_d;
            presc_cnt_q <= presc_cnt_d;
            pause_cnt_q <= pause_cnt_d;
            loop_cnt_q  <= loop_cnt_d;
            en_q        <= en_d;
            irq_q       <= irq_d;
        end
    end

    assign ptr     = ptr_q;
    assign en      = en_q;
    assign pausing = (pause_cnt_q != 12'd0);
    assign irq     = irq_q;

endmodule

// File: rtl/amstrad_dma_sequencer.sv
// amstrad_dma_sequencer
// Line-synchronous sound DMA sequencer. On every line_tick it walks the
// channels in order and gives each enabled channel one service slot: either
// one pause step or one fetched-and-executed instruction.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   line_tick           : one pulse per scan line
//   reg_we/ch/sel/wdata : CPU register write port
//   bus (master)        : RAM word read port and PSG register write port
//   irq                 : per-channel sticky interrupt flags
//   overrun             : sticky, a tick arrived while one was already pending
//   busy                : sequencer is servicing channels
module amstrad_dma_sequencer
    import amstrad_dma_pkg::*;
#(
    parameter int CHANNELS = 3,
    parameter int ADDR_W   = 16,
    parameter int CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                line_tick,
    input  logic                reg_we,
    input  logic [CW-1:0]       reg_ch,
    input  logic [1:0]          reg_sel,
    input  logic [15:0]         reg_wdata,
    amstrad_dma_if.master       bus,
    output logic [CHANNELS-1:0] irq,
    output logic                overrun,
    output logic                busy
);

    state_e            state_q, state_d;
    logic [CW-1:0]     ch_q, ch_d;
    logic              pause_slot_q, pause_slot_d;
    logic [15:0]       instr_q, instr_d;
    logic              mem_req_q, mem_req_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              psg_we_q, psg_we_d;
    logic [3:0]        psg_reg_q, psg_reg_d;
    logic [7:0]        psg_data_q, psg_data_d;
    logic              pending_q, pending_d;
    logic              overrun_q, overrun_d;

    logic              fetch_done;
    logic              exec_instr;
    logic              pause_step;
    logic              advance;
    logic              status_we;

    logic [ADDR_W-1:0] ch_ptr [CHANNELS];
    logic [CHANNELS-1:0] ch_en;
    logic [CHANNELS-1:0] ch_pausing;

    assign status_we = reg_we && (reg_sel == SEL_STATUS);

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        amstrad_dma_channel #(
            .ADDR_W(ADDR_W)
        ) u_ch (
            .clk           (clk),
            .reset         (reset),
            .cfg_we        (reg_we && (reg_ch == CW'(g))),
            .cfg_sel       (reg_sel),
            .cfg_wdata     (reg_wdata),
            .irq_clr       (status_we && reg_wdata[g]),
            .fetch_done    (fetch_done && (ch_q == CW'(g))),
            .fetch_next_ptr(mem_addr_q + ADDR_W'(2)),
            .exec_instr    (exec_instr && (ch_q == CW'(g))),
            .instr         (instr_q),
            .pause_step    (pause_step && (ch_q == CW'(g))),
            .ptr           (ch_ptr[g]),
            .en            (ch_en[g]),
            .pausing       (ch_pausing[g]),
            .irq           (irq[g])
        );
    end

    always_comb begin
        state_d      = state_q;
        ch_d         = ch_q;
        pause_slot_d = pause_slot_q;
        instr_d      = instr_q;
        mem_req_d    = mem_req_q;
        mem_addr_d   = mem_addr_q;
        psg_we_d     = psg_we_q;
        psg_reg_d    = psg_reg_q;
        psg_data_d   = psg_data_q;
        pending_d    = pending_q;
        overrun_d    = overrun_q;
        fetch_done   = 1'b0;
        exec_instr   = 1'b0;
        pause_step   = 1'b0;
        advance      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (line_tick || pending_q) begin
                    state_d   = ST_SCAN;
                    ch_d      = '0;
                    pending_d = 1'b0;
                end
            end
            ST_SCAN: begin
                if (ch_en[ch_q]) begin
                    // the slot kind is fixed here; later writes cannot split it
                    pause_slot_d = ch_pausing[ch_q];
                    state_d      = ch_pausing[ch_q] ? ST_EXEC : ST_FETCH;
                end else begin
                    advance = 1'b1;
                end
            end
            ST_FETCH: begin
                if (!mem_req_q) begin
                    // address is latched so pointer writes cannot disturb the request
                    mem_req_d  = 1'b1;
                    mem_addr_d = ch_ptr[ch_q];
                end else if (bus.mem_ack) begin
                    mem_req_d  = 1'b0;
                    instr_d    = bus.mem_rdata;
                    fetch_done = 1'b1;
                    state_d    = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (pause_slot_q) begin
                    pause_step = 1'b1;
                    advance    = 1'b1;
                end else begin
                    exec_instr = 1'b1;
                    if (instr_q[15:12] == OP_LOAD) begin
                        psg_we_d   = 1'b1;
                        psg_reg_d  = instr_q[11:8];
                        psg_data_d = instr_q[7:0];
                        state_d    = ST_PSG_WR;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            ST_PSG_WR: begin
                if (bus.psg_ready) begin
                    psg_we_d = 1'b0;
                    advance  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (advance) begin
            if (ch_q == CW'(CHANNELS - 1)) begin
                state_d = ST_IDLE;
            end else begin
                ch_d    = ch_q + CW'(1);
                state_d = ST_SCAN;
            end
        end

        if (status_we && reg_wdata[15]) begin
            overrun_d = 1'b0;
        end

        // one tick of slack is remembered; a second one while pending is lost
        if (line_tick && (state_q != ST_IDLE)) begin
            if (pending_q) begin
                overrun_d = 1'b1;
            end else begin
                pending_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            ch_q         <= '0;
            pause_slot_q <= 1'b0;
            instr_q      <= '0;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
            psg_we_q     <= 1'b0;
            psg_reg_q    <= '0;
            psg_data_q   <= '0;
            pending_q    <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            ch_q         <= ch_d;
            pause_slot_q <= pause_slot_d;
            instr_q      <= instr_d;
            mem_req_q    <= mem_req_d;
            mem_addr_q   <= mem_addr_d;
            psg_we_q     <= psg_we_d;
            psg_reg_q    <= psg_reg_d;
            psg_data_q   <= psg_data_d;
            pending_q    <= pending_d;
            overrun_q    <= overrun_d;
        end
    end

    assign bus.mem_req  = mem_req_q;
    assign bus.mem_addr = mem_addr_q;
    assign bus.psg_we   = psg_we_q;
    assign bus.psg_reg  = psg_reg_q;
    assign bus.psg_data = psg_data_q;
    assign overrun      = overrun_q;
    assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_amstrad_dma_sequencer.sv
// tb_amstrad_dma_sequencer
// Scoreboard bench: expected fetch addresses and PSG writes are queued as
// stimulus is issued; a negedge monitor pops and compares on every completed
// memory read and PSG write. Status outputs and slot latencies are compared
// directly.
module tb_amstrad_dma_sequencer;
    import amstrad_dma_pkg::*;

    logic        clk;
    logic        reset;
    logic        line_tick;
    logic        reg_we;
    logic [1:0]  reg_ch;
    logic [1:0]  reg_sel;
    logic [15:0] reg_wdata;
    logic [2:0]  irq;
    logic        overrun;
    logic        busy;
    logic        ack_en;
    logic        psg_rdy_en;

    logic [15:0] mem_words [0:65535];
    logic [15:0] exp_fetch_q [$];
    logic [11:0] exp_psg_q [$];

    int checks;
    int failures;

    amstrad_dma_if #(.ADDR_W(16)) bus ();

    amstrad_dma_sequencer #(
        .CHANNELS(3),
        .ADDR_W  (16)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .line_tick(line_tick),
        .reg_we   (reg_we),
        .reg_ch   (reg_ch),
        .reg_sel  (reg_sel),
        .reg_wdata(reg_wdata),
        .bus      (bus),
        .irq      (irq),
        .overrun  (overrun),
        .busy     (busy)
    );

    assign bus.mem_ack   = bus.mem_req & ack_en;
    assign bus.mem_rdata = mem_words[bus.mem_addr];
    assign bus.psg_ready = bus.psg_we & psg_rdy_en;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: completed transactions are checked against the queues
    always @(negedge clk) begin
        if (bus.mem_req && bus.mem_ack) begin
            checks++;
            if (exp_fetch_q.size() == 0) begin
                failures++;
                $display("FAIL fetch_addr actual=%h required=<no fetch>", bus.mem_addr);
            end else begin
                logic [15:0] e;
                e = exp_fetch_q.pop_front();
                if (bus.mem_addr !== e) begin
                    failures++;
                    $display("FAIL fetch_addr actual=%h required=%h", bus.mem_addr, e);
                end
            end
        end
        if (bus.psg_we && bus.psg_ready) begin
            checks++;
            if (exp_psg_q.size() == 0) begin
                failures++;
                $display("FAIL psg_write actual=%h/%h required=<no write>", bus.psg_reg, bus.psg_data);
            end else begin
                logic [11:0] p;
                p = exp_psg_q.pop_front();
                if ({bus.psg_reg, bus.psg_data} !== p) begin
                    failures++;
                    $display("FAIL psg_write actual=%h/%h required=%h/%h",
                             bus.psg_reg, bus.psg_data, p[11:8], p[7:0]);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic reg_write(input logic [1:0] ch, input logic [1:0] sel, input logic [15:0] d);
        reg_we    = 1'b1;
        reg_ch    = ch;
        reg_sel   = sel;
        reg_wdata = d;
        cyc();
        reg_we    = 1'b0;
    endtask

    task automatic tick();
        line_tick = 1'b1;
        cyc();
        line_tick = 1'b0;
    endtask

    // Waits for busy to drop; exp_cycles < 0 skips the latency comparison
    task automatic wait_idle(input string name, input int exp_cycles);
        int n;
        n = 0;
        while (busy && n < 300) begin
            cyc();
            n++;
        end
        check({name, "_idle"}, busy, 0);
        if (exp_cycles >= 0) check({name, "_cycles"}, n, exp_cycles);
    endtask

    task automatic tick_serviced(input string name, input int exp_cycles);
        tick();
        wait_idle(name, exp_cycles);
    endtask

    initial begin
        int lat3 [8];
        int n;
        lat3 = '{6, 7, 6, 7, 6, 7, 6, 6};

        checks     = 0;
        failures   = 0;
        reset      = 1'b1;
        line_tick  = 1'b0;
        reg_we     = 1'b0;
        reg_ch     = 2'd0;
        reg_sel    = 2'd0;
        reg_wdata  = 16'h0000;
        ack_en     = 1'b1;
        psg_rdy_en = 1'b1;
        for (int i = 0; i < 65536; i++) mem_words[i] = 16'h3000;
        mem_words[16'h4000] = 16'h0A3F;
        mem_words[16'h4002] = 16'h4020;
        mem_words[16'h5000] = 16'h1003;
        mem_words[16'h5002] = 16'h0105;
        mem_words[16'h6000] = 16'h2002;
        mem_words[16'h6002] = 16'h0701;
        mem_words[16'h6004] = 16'h4001;
        mem_words[16'h6006] = 16'h4030;

        cyc();
        cyc();
        reset = 1'b0;
        check("rst_irq", irq, 0);
        check("rst_overrun", overrun, 0);
        check("rst_busy", busy, 0);
        check("rst_mem_req", bus.mem_req, 0);
        check("rst_psg_we", bus.psg_we, 0);

        // ch0: LOAD then STOP
        reg_write(2'd0, SEL_PTR, 16'h4000);
        reg_write(2'd0, SEL_CTRL, 16'h0001);
        exp_fetch_q.push_back(16'h4000);
        exp_psg_q.push_back({4'hA, 8'h3F});
        tick_serviced("ch0_load", 7);
        exp_fetch_q.push_back(16'h4002);
        tick_serviced("ch0_stop", 6);
        check("ch0_irq", irq, 0);
        tick_serviced("ch0_stopped", 3);

        // ch1: PAUSE 3 with prescale 1, LOAD on the 8th tick
        reg_write(2'd1, SEL_PTR, 16'h5000);
        reg_write(2'd1, SEL_PRESC, 16'h0001);
        reg_write(2'd1, SEL_CTRL, 16'h0001);
        exp_fetch_q.push_back(16'h5000);
        tick_serviced("ch1_pause_fetch", 6);
        for (int t = 0; t < 6; t++) tick_serviced("ch1_pause_step", 4);
        check("ch1_psg_not_yet", exp_psg_q.size(), 0);
        exp_fetch_q.push_back(16'h5002);
        exp_psg_q.push_back({4'h1, 8'h05});
        tick_serviced("ch1_load", 7);
        reg_write(2'd1, SEL_CTRL, 16'h0000);

        // ch2: REPEAT 2 around a LOAD, then INT+STOP
        reg_write(2'd2, SEL_PTR, 16'h6000);
        reg_write(2'd2, SEL_CTRL, 16'h0001);
        exp_fetch_q.push_back(16'h6000);
        for (int k = 0; k < 3; k++) begin
            exp_fetch_q.push_back(16'h6002);
            exp_psg_q.push_back({4'h7, 8'h01});
            exp_fetch_q.push_back(16'h6004);
        end
        exp_fetch_q.push_back(16'h6006);
        for (int t = 0; t < 8; t++) begin
            tick_serviced("ch2_repeat", lat3[t]);
            if (t == 6) check("ch2_irq_before_int", irq, 0);
        end
        check("ch2_irq_set", irq, 3'b100);
        tick_serviced("ch2_stopped", 3);
        reg_write(2'd0, SEL_STATUS, 16'h0004);
        check("ch2_irq_cleared", irq, 0);

        // Stalled memory: pending then overrun
        reg_write(2'd0, SEL_PTR, 16'h7000);
        reg_write(2'd0, SEL_CTRL, 16'h0001);
        ack_en = 1'b0;
        exp_fetch_q.push_back(16'h7000);
        tick();
        cyc();
        cyc();
        tick();
        check("ovr_after_first", overrun, 0);
        tick();
        check("ovr_after_second", overrun, 1);
        tick();
        exp_fetch_q.push_back(16'h7002);
        ack_en = 1'b1;
        wait_idle("ovr_finish", 4);
        cyc();
        check("ovr_restart_busy", busy, 1);
        wait_idle("ovr_restart", 6);
        cyc();
        check("ovr_no_second_restart", busy, 0);
        check("ovr_sticky", overrun, 1);
        reg_write(2'd0, SEL_STATUS, 16'h8000);
        check("ovr_cleared", overrun, 0);
        reg_write(2'd0, SEL_CTRL, 16'h0000);

        // Pointer wrap
        reg_write(2'd1, SEL_PTR, 16'hFFFE);
        reg_write(2'd1, SEL_CTRL, 16'h0001);
        exp_fetch_q.push_back(16'hFFFE);
        tick_serviced("wrap_first", 6);
        exp_fetch_q.push_back(16'h0000);
        tick_serviced("wrap_second", 6);
        reg_write(2'd1, SEL_CTRL, 16'h0000);

        // Reset while a PSG write is stalled
        reg_write(2'd2, SEL_PTR, 16'h6006);
        reg_write(2'd2, SEL_CTRL, 16'h0001);
        exp_fetch_q.push_back(16'h6006);
        tick_serviced("rst_int", 6);
        check("rst_pre_irq", irq, 3'b100);
        reg_write(2'd0, SEL_PTR, 16'h4000);
        reg_write(2'd0, SEL_CTRL, 16'h0001);
        psg_rdy_en = 1'b0;
        exp_fetch_q.push_back(16'h4000);
        tick();
        n = 0;
        while (!bus.psg_we && n < 20) begin
            cyc();
            n++;
        end
        check("rst_psg_we_up", bus.psg_we, 1);
        cyc();
        check("rst_psg_held", {bus.psg_we, bus.psg_reg, bus.psg_data}, {1'b1, 4'hA, 8'h3F});
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        check("rst_mid_psg_we", bus.psg_we, 0);
        check("rst_mid_irq", irq, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_mem_req", bus.mem_req, 0);
        psg_rdy_en = 1'b1;
        cyc();
        cyc();
        tick_serviced("rst_all_disabled", 3);

        check("fetch_queue_drained", exp_fetch_q.size(), 0);
        check("psg_queue_drained", exp_psg_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
